// File: rtl/dlx_wb_pkg.sv
// Shared definitions for the writeback stage: opcode encodings, instruction
// field positions and the opcode-class decode used by the stage and its aligner.
package dlx_wb_pkg;

  localparam logic [5:0] OP_LB   = 6'b000001;
  localparam logic [5:0] OP_LBU  = 6'b000010;
  localparam logic [5:0] OP_LH   = 6'b000011;
  localparam logic [5:0] OP_LHU  = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b000101;
  localparam logic [5:0] ADDI_LO = 6'b010000;
  localparam logic [5:0] ADDI_HI = 6'b011111;
  localparam logic [5:0] R_TYPE  = 6'b110000;

  localparam int OPC_MSB = 32'd31;
  localparam int OPC_LSB = 32'd26;
  localparam int RT_MSB  = 32'd20;
  localparam int RT_LSB  = 32'd16;
  localparam int RD_MSB  = 32'd15;
  localparam int RD_LSB  = 32'd11;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_ALU  = 2'd1,
    CLS_LOAD = 2'd2
  } wb_cls_e;

  function automatic wb_cls_e opcode_class(input logic [5:0] opc);
    wb_cls_e cls;
    if ((opc >= OP_LB) && (opc <= OP_LW)) begin
      cls = CLS_LOAD;
    end else if (((opc >= ADDI_LO) && (opc <= ADDI_HI)) || (opc == R_TYPE)) begin
      cls = CLS_ALU;
    end else begin
      cls = CLS_NONE;
    end
    return cls;
  endfunction

endpackage

// File: rtl/writeback_stage_p_load_align_ext.sv
// Sub-word load extraction: picks the byte/halfword lane addressed by the
// effective-address offset, extends it, and flags misaligned accesses.
module load_align_ext
  import dlx_wb_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] mem_word,
  input  logic [1:0]  offset,
  input  logic [5:0]  opcode,
  output logic [31:0] ext_data,
  output logic        misaligned
);

  logic [4:0]  byte_sh_s;
  logic [4:0]  half_sh_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select: big-endian puts offset 0 in the most significant lane
  always_comb begin
    if (BIG_ENDIAN) begin
      byte_sh_s = 5'd24 - {offset, 3'b000};
      half_sh_s = offset[1] ? 5'd0 : 5'd16;
    end else begin
      byte_sh_s = {offset, 3'b000};
      half_sh_s = offset[1] ? 5'd16 : 5'd0;
    end
    byte_s = 8'(mem_word >> byte_sh_s);
    half_s = 16'(mem_word >> half_sh_s);
  end

  // Extension and alignment check per load opcode
  always_comb begin
    ext_data   = 32'h0000_0000;
    misaligned = 1'b0;
    case (opcode)
      OP_LB:  ext_data = {{24{byte_s[7]}}, byte_s};
      OP_LBU: ext_data = {24'h00_0000, byte_s};
      OP_LH: begin
        ext_data   = {{16{half_s[15]}}, half_s};
        misaligned = offset[0];
      end
      OP_LHU: begin
        ext_data   = {16'h0000, half_s};
        misaligned = offset[0];
      end
      OP_LW: begin
        ext_data   = mem_word;
        misaligned = (offset != 2'b00);
      end
      default: begin
        ext_data   = 32'h0000_0000;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage_p.sv
// MEM/WB pipeline register and register-file write selection, with a bypass
// tap, a saturating retired-instruction counter and a sticky misalign flag.
module writeback_stage_p
  import dlx_wb_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter bit ZERO_GUARD = 1'b1
) (
  input  logic             clock5,
  input  logic             reset5,
  input  logic [31:0]      inst_in5,
  input  logic [31:0]      alu_in5,
  input  logic [31:0]      loadmemdata_in,
  input  logic             valid_in5,
  input  logic             stall5,
  input  logic             flush5,
  input  logic             err_clear,
  output logic [4:0]       reg_add_out,
  output logic [31:0]      reg_data_out,
  output logic             reg_write_en,
  output logic             fwd_valid,
  output logic [CNT_W-1:0] retired_count,
  output logic             misalign_err
);

  logic [31:0]      ir6_r;
  logic [31:0]      alu_r;
  logic [31:0]      mem_r;
  logic             valid_r;
  logic [CNT_W-1:0] count_r;
  logic             misalign_r;

  logic [5:0]  opc_s;
  wb_cls_e     cls_s;
  logic [31:0] ext_s;
  logic        misal_s;
  logic [4:0]  dest_s;
  logic [31:0] data_s;
  logic        retire_s;
  logic        wb_ok_s;
  logic        unused_fields_s;

  assign opc_s           = ir6_r[OPC_MSB:OPC_LSB];
  assign cls_s           = opcode_class(opc_s);
  assign unused_fields_s = ^{ir6_r[25:21], ir6_r[10:0]};

  load_align_ext #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_align (
    .mem_word   (mem_r),
    .offset     (alu_r[1:0]),
    .opcode     (opc_s),
    .ext_data   (ext_s),
    .misaligned (misal_s)
  );

  // Stage registers: flush kills validity but still loads data, stall holds all
  always_ff @(posedge clock5 or negedge reset5) begin
    if (!reset5) begin
      ir6_r   <= 32'h0000_0000;
      alu_r   <= 32'h0000_0000;
      mem_r   <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else if (flush5) begin
      ir6_r   <= inst_in5;
      alu_r   <= alu_in5;
      mem_r   <= loadmemdata_in;
      valid_r <= 1'b0;
    end else if (stall5) begin
      ir6_r   <= ir6_r;
      alu_r   <= alu_r;
      mem_r   <= mem_r;
      valid_r <= valid_r;
    end else begin
      ir6_r   <= inst_in5;
      alu_r   <= alu_in5;
      mem_r   <= loadmemdata_in;
      valid_r <= valid_in5;
    end
  end

  // Destination and write-data selection by opcode class
  always_comb begin
    dest_s = 5'd0;
    data_s = 32'h0000_0000;
    case (cls_s)
      CLS_ALU: begin
        dest_s = (opc_s == R_TYPE) ? ir6_r[RD_MSB:RD_LSB] : ir6_r[RT_MSB:RT_LSB];
        data_s = alu_r;
      end
      CLS_LOAD: begin
        dest_s = ir6_r[RT_MSB:RT_LSB];
        data_s = ext_s;
      end
      default: begin
        dest_s = 5'd0;
        data_s = 32'h0000_0000;
      end
    endcase
  end

  // A held instruction retires only in its first non-stalled cycle
  assign retire_s = valid_r & ~stall5;
  assign wb_ok_s  = retire_s
                  & ((cls_s == CLS_ALU) | ((cls_s == CLS_LOAD) & ~misal_s))
                  & ~(ZERO_GUARD & (dest_s == 5'd0));

  // Saturating retired-instruction counter
  always_ff @(posedge clock5 or negedge reset5) begin
    if (!reset5) begin
      count_r <= {CNT_W{1'b0}};
    end else if (retire_s && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + CNT_W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  // Sticky misalign flag; a new misaligned retire beats a same-cycle clear
  always_ff @(posedge clock5 or negedge reset5) begin
    if (!reset5) begin
      misalign_r <= 1'b0;
    end else if (retire_s && (cls_s == CLS_LOAD) && misal_s) begin
      misalign_r <= 1'b1;
    end else if (err_clear) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign reg_add_out   = dest_s;
  assign reg_data_out  = data_s;
  assign reg_write_en  = wb_ok_s;
  assign fwd_valid     = wb_ok_s;
  assign retired_count = count_r;
  assign misalign_err  = misalign_r;

endmodule

// File: tb/tb_writeback_stage_p.sv
// Directed bench for writeback_stage_p: three configurations share stimulus,
// expected write-port values go through a scoreboard queue.
module tb_writeback_stage_p;

  typedef struct packed {
    logic        we_be;
    logic        we_le;
    logic [4:0]  addr;
    logic [31:0] data_be;
    logic [31:0] data_le;
    logic        mis;
  } exp_t;

  logic        clock5 = 1'b0;
  logic        reset5 = 1'b0;
  logic [31:0] inst_in5 = 32'h0;
  logic [31:0] alu_in5 = 32'h0;
  logic [31:0] loadmemdata_in = 32'h0;
  logic        valid_in5 = 1'b0;
  logic        stall5 = 1'b0;
  logic        flush5 = 1'b0;
  logic        err_clear = 1'b0;

  logic [4:0]  add_be, add_le, add_c2;
  logic [31:0] data_be, data_le, data_c2;
  logic        we_be, we_le, we_c2;
  logic        fwd_be, fwd_le, fwd_c2;
  logic [15:0] cnt_be, cnt_le;
  logic [1:0]  cnt_c2;
  logic        mis_be, mis_le, mis_c2;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  logic        m_valid;
  logic [31:0] m_inst, m_alu;
  int          exp_cnt, exp_cnt2;
  logic        exp_mis;

  always #5 clock5 = ~clock5;

  writeback_stage_p #(.CNT_W(16), .BIG_ENDIAN(1'b1), .ZERO_GUARD(1'b1)) u_be (
    .clock5(clock5), .reset5(reset5), .inst_in5(inst_in5), .alu_in5(alu_in5),
    .loadmemdata_in(loadmemdata_in), .valid_in5(valid_in5), .stall5(stall5),
    .flush5(flush5), .err_clear(err_clear), .reg_add_out(add_be),
    .reg_data_out(data_be), .reg_write_en(we_be), .fwd_valid(fwd_be),
    .retired_count(cnt_be), .misalign_err(mis_be));

  writeback_stage_p #(.CNT_W(16), .BIG_ENDIAN(1'b0), .ZERO_GUARD(1'b0)) u_le (
    .clock5(clock5), .reset5(reset5), .inst_in5(inst_in5), .alu_in5(alu_in5),
    .loadmemdata_in(loadmemdata_in), .valid_in5(valid_in5), .stall5(stall5),
    .flush5(flush5), .err_clear(err_clear), .reg_add_out(add_le),
    .reg_data_out(data_le), .reg_write_en(we_le), .fwd_valid(fwd_le),
    .retired_count(cnt_le), .misalign_err(mis_le));

  writeback_stage_p #(.CNT_W(2), .BIG_ENDIAN(1'b1), .ZERO_GUARD(1'b1)) u_c2 (
    .clock5(clock5), .reset5(reset5), .inst_in5(inst_in5), .alu_in5(alu_in5),
    .loadmemdata_in(loadmemdata_in), .valid_in5(valid_in5), .stall5(stall5),
    .flush5(flush5), .err_clear(err_clear), .reg_add_out(add_c2),
    .reg_data_out(data_c2), .reg_write_en(we_c2), .fwd_valid(fwd_c2),
    .retired_count(cnt_c2), .misalign_err(mis_c2));

  function automatic logic [31:0] rtype(input logic [4:0] rd);
    return {6'b110000, 5'd1, 5'd2, rd, 11'h7FF};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd31, rt, 16'hA5A5};
  endfunction

  // Reference behaviour of one instruction sitting in the stage
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic valid);
    exp_t e;
    logic [5:0] op;
    logic [1:0] off;
    logic [7:0] bbe, ble;
    logic [15:0] hbe, hle;
    logic ld, al;
    op  = inst[31:26];
    off = alu[1:0];
    case (off)
      2'd0:    begin bbe = mem[31:24]; ble = mem[7:0];   end
      2'd1:    begin bbe = mem[23:16]; ble = mem[15:8];  end
      2'd2:    begin bbe = mem[15:8];  ble = mem[23:16]; end
      default: begin bbe = mem[7:0];   ble = mem[31:24]; end
    endcase
    hbe = off[1] ? mem[15:0] : mem[31:16];
    hle = off[1] ? mem[31:16] : mem[15:0];
    ld  = (op >= 6'd1) && (op <= 6'd5);
    al  = ((op >= 6'b010000) && (op <= 6'b011111)) || (op == 6'b110000);
    e = '0;
    e.addr = (op == 6'b110000) ? inst[15:11] : ((ld || al) ? inst[20:16] : 5'd0);
    e.mis  = (((op == 6'd3) || (op == 6'd4)) && off[0]) || ((op == 6'd5) && (off != 2'd0));
    if (al) begin
      e.data_be = alu;
      e.data_le = alu;
    end else if (ld) begin
      case (op)
        6'd1: begin e.data_be = {{24{bbe[7]}}, bbe}; e.data_le = {{24{ble[7]}}, ble}; end
        6'd2: begin e.data_be = {24'h0, bbe}; e.data_le = {24'h0, ble}; end
        6'd3: begin e.data_be = {{16{hbe[15]}}, hbe}; e.data_le = {{16{hle[15]}}, hle}; end
        6'd4: begin e.data_be = {16'h0, hbe}; e.data_le = {16'h0, hle}; end
        default: begin e.data_be = mem; e.data_le = mem; end
      endcase
    end
    e.we_le = valid && (al || (ld && !e.mis));
    e.we_be = e.we_le && (e.addr != 5'd0);
    return e;
  endfunction

  // Retire-count and sticky-flag reference, fed by the bench's own stimulus
  always @(posedge clock5 or negedge reset5) begin
    if (!reset5) begin
      m_valid <= 1'b0; m_inst <= 32'h0; m_alu <= 32'h0;
      exp_cnt <= 0; exp_cnt2 <= 0; exp_mis <= 1'b0;
    end else begin
      if (m_valid && !stall5) begin
        exp_cnt  <= exp_cnt + 1;
        exp_cnt2 <= (exp_cnt2 == 3) ? 3 : exp_cnt2 + 1;
      end
      if (m_valid && !stall5 && model(m_inst, m_alu, 32'h0, 1'b1).mis) exp_mis <= 1'b1;
      else if (err_clear) exp_mis <= 1'b0;
      if (flush5) begin
        m_valid <= 1'b0; m_inst <= inst_in5; m_alu <= alu_in5;
      end else if (!stall5) begin
        m_valid <= valid_in5; m_inst <= inst_in5; m_alu <= alu_in5;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic stalled);
    exp_t e;
    e = model(inst_in5, alu_in5, loadmemdata_in, valid_in5 && !flush5);
    if (stalled) begin
      e.we_be = 1'b0;
      e.we_le = 1'b0;
    end
    sb_q.push_back(e);
  endtask

  task automatic sample(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "/sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "/we_be"},  {31'd0, we_be},  {31'd0, e.we_be});
      chk({tag, "/fwd_be"}, {31'd0, fwd_be}, {31'd0, e.we_be});
      chk({tag, "/add_be"}, {27'd0, add_be}, {27'd0, e.addr});
      chk({tag, "/dat_be"}, data_be, e.data_be);
      chk({tag, "/we_le"},  {31'd0, we_le},  {31'd0, e.we_le});
      chk({tag, "/add_le"}, {27'd0, add_le}, {27'd0, e.addr});
      chk({tag, "/dat_le"}, data_le, e.data_le);
      chk({tag, "/cnt"},    {16'd0, cnt_be}, 32'(exp_cnt));
      chk({tag, "/cnt_c2"}, {30'd0, cnt_c2}, 32'(exp_cnt2));
      chk({tag, "/mis"},    {31'd0, mis_be}, {31'd0, exp_mis});
      chk({tag, "/mis_le"}, {31'd0, mis_le}, {31'd0, exp_mis});
    end
  endtask

  task automatic step(input string tag, input logic [31:0] inst, input logic [31:0] alu,
                      input logic [31:0] mem, input logic valid, input logic flush);
    @(negedge clock5);
    inst_in5 = inst; alu_in5 = alu; loadmemdata_in = mem;
    valid_in5 = valid; flush5 = flush;
    push_exp(1'b0);
    @(posedge clock5);
    #1;
    flush5 = 1'b0;
    sample(tag);
  endtask

  initial begin
    int cnt_before;
    @(posedge clock5);
    #1;
    chk("rst/add", {27'd0, add_be}, 32'd0);
    chk("rst/data", data_be, 32'd0);
    chk("rst/we", {30'd0, we_be, fwd_be}, 32'd0);
    chk("rst/cnt_mis", {15'd0, cnt_be, mis_be}, 32'd0);
    @(negedge clock5);
    reset5 = 1'b1;

    step("rtype7", rtype(5'd7), 32'h0000_1234, 32'h0, 1'b1, 1'b0);
    step("lb",     itype(6'd1, 5'd3), 32'h0000_1001, 32'h11F2_3344, 1'b1, 1'b0);
    chk("lb_be_val", data_be, 32'hFFFF_FFF2);
    chk("lb_le_val", data_le, 32'h0000_0033);
    chk("rtype_retired", {16'd0, cnt_be}, 32'd1);
    step("lbu",    itype(6'd2, 5'd3), 32'h0000_1001, 32'h11F2_3344, 1'b1, 1'b0);
    chk("lbu_be_val", data_be, 32'h0000_00F2);
    step("lh",     itype(6'd3, 5'd4), 32'h0000_0002, 32'h8001_7FFE, 1'b1, 1'b0);
    step("lhu",    itype(6'd4, 5'd4), 32'h0000_0000, 32'h8001_7FFE, 1'b1, 1'b0);
    step("lb_off3", itype(6'd1, 5'd8), 32'h0000_0003, 32'h80FF_7F81, 1'b1, 1'b0);
    step("lw_mis2", itype(6'd5, 5'd5), 32'h0000_0002, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step("lw_mis1", itype(6'd5, 5'd5), 32'h0000_0001, 32'hCAFE_F00D, 1'b1, 1'b0);
    chk("mis_set", {31'd0, mis_be}, 32'd1);
    err_clear = 1'b1;
    step("nop_clr", itype(6'b111111, 5'd6), 32'h0000_0042, 32'h0, 1'b1, 1'b0);
    chk("mis_set_wins", {31'd0, mis_be}, 32'd1);
    step("addi_r0", itype(6'b010000, 5'd0), 32'h0000_0055, 32'h0, 1'b1, 1'b0);
    chk("mis_cleared", {31'd0, mis_be}, 32'd0);
    err_clear = 1'b0;
    step("flush", rtype(5'd7), 32'h0000_0077, 32'h0, 1'b1, 1'b1);

    // ADDI held for three stalled cycles, then written exactly once
    step("addi9", itype(6'b011111, 5'd9), 32'h0000_ABCD, 32'h0, 1'b1, 1'b0);
    sb_q.delete();
    cnt_before = exp_cnt;
    @(posedge clock5);
    #1;
    inst_in5 = itype(6'b011111, 5'd9);
    alu_in5 = 32'h0000_ABCD;
    @(negedge clock5);
    // Re-issue ADDI so it sits in the stage, then stall it
    @(posedge clock5);
    #1;
    stall5 = 1'b1;
    inst_in5 = rtype(5'd12); alu_in5 = 32'h0000_0999;
    cnt_before = int'(cnt_be);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge clock5);
        #1;
      end
      #1;
      sb_q.push_back(model(itype(6'b011111, 5'd9), 32'h0000_ABCD, 32'h0, 1'b0));
      sample("stall");
    end
    @(negedge clock5);
    stall5 = 1'b0; valid_in5 = 1'b0; inst_in5 = 32'h0;
    #1;
    sb_q.push_back(model(itype(6'b011111, 5'd9), 32'h0000_ABCD, 32'h0, 1'b1));
    sample("unstall");
    @(posedge clock5);
    #1;
    push_exp(1'b0);
    sample("after_unstall");
    chk("stall_retire_once", {16'd0, cnt_be}, 32'(cnt_before + 1));
    chk("c2_saturated", {30'd0, cnt_c2}, 32'd3);

    // Reset while an aligned LW is held under stall
    step("lw_ok", itype(6'd5, 5'd6), 32'h0000_0004, 32'h0BAD_F00D, 1'b1, 1'b0);
    stall5 = 1'b1;
    #1;
    chk("lw_stalled_we", {31'd0, we_be}, 32'd0);
    #1;
    reset5 = 1'b0;
    #1;
    chk("rst_mid/add", {27'd0, add_be}, 32'd0);
    chk("rst_mid/data", data_be, 32'd0);
    chk("rst_mid/we", {29'd0, we_be, fwd_be, we_c2}, 32'd0);
    chk("rst_mid/cnt_mis", {14'd0, cnt_be, cnt_c2, mis_be}, 32'd0);
    @(negedge clock5);
    reset5 = 1'b1;
    stall5 = 1'b0; valid_in5 = 1'b0;
    @(posedge clock5);
    #1;
    chk("post_rst_we", {30'd0, we_be, fwd_be}, 32'd0);
    chk("post_rst_cnt", {16'd0, cnt_be}, 32'd0);
    step("post_rst_rtype", rtype(5'd7), 32'h0000_1234, 32'h0, 1'b1, 1'b0);
    chk("post_rst_write", {31'd0, we_be}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
